inst_loader: RTL
================

# inst_loader

Writable instruction store for the 9-bit ISA core. It accepts a program as a stream of W-bit instruction words over a valid/ready handshake and writes them into an internal memory. It then serves them to the fetch stage through the same combinational InstAddress/InstOut read port the core already uses. Together, the two sides replace the hard-coded instruction table: a test harness or host pushes a program in, then releases the core to run it.

## Interface
- A, 10: instruction address width; the memory holds 2**A words.
- W, 9: instruction word width.
- CLK  in  1  clock; all state updates on the rising edge.
- Reset_n  in  1  reset, asynchronous, active-low.
- Start  in  1  single-cycle pulse that begins or restarts a load.
- InData  in  W  instruction word to write.
- InValid  in  1  InData is valid.
- InReady  out  1  loader accepts InData this cycle.
- InstAddress  in  A  fetch address from the program counter.
- InstOut  out  W  instruction at InstAddress; combinational.
- Done  out  1  a complete program is loaded and the read port is live.
- Overflow  out  1  the memory filled before an END word arrived.
- LoadCount  out  A+1  number of words written in the current or last load.

## Operation
- END word is all-ones (9'b111_11_11_11), the ISA's halt encoding.
- States: IDLE, LOAD, DONE, ERR.
- Reset (async, Reset_n=0): state IDLE, write address 0, LoadCount 0, Done 0, Overflow 0, InReady 0. Memory contents are not reset.
- IDLE: InReady 0. Start moves to LOAD.
- Entering LOAD on any Start: write address 0, LoadCount 0, Done 0, Overflow 0.
- LOAD: InReady = 1 unless Start is high this cycle.
  - A beat is InValid && InReady. On a beat: mem[addr] = InData, addr+1, LoadCount+1.
  - Beat carrying the END word: it is written and counted, then the state moves to DONE.
  - Non-END beat at addr = 2**A-1: the word is written and the state moves to ERR. The address never wraps.
  - END beat at addr = 2**A-1: moves to DONE. END takes priority over overflow.
- Start during LOAD restarts the load. Start has priority over a simultaneous beat, which is not accepted because InReady is 0.
- DONE: Done 1.
  - InstOut = mem[InstAddress] when InstAddress < LoadCount.
  - InstOut = END word when InstAddress >= LoadCount, so stale memory is never visible.
  - Start moves to LOAD.
- ERR: Overflow 1, Done 0, InReady 0. Start moves to LOAD.
- In every state other than DONE, InstOut = END word, so a core fetching during a load halts.
- LoadCount saturates naturally at 2**A, which is why it is A+1 bits wide.

## Timing
- Write latency: a word accepted at edge k is readable from edge k+1, once DONE has been entered.
- Done and Overflow are registered. Each asserts in the cycle after the terminating beat.
- InReady is combinational from state and Start only. It never depends on InValid.
- InstOut is purely combinational from InstAddress, state and LoadCount, with zero-cycle latency.
- Reset asserted mid-load: outputs drop immediately to their reset values. A partially written program is not served.
- Throughput: one word per cycle while in LOAD.

## Structure
- Shared package isa_pkg:
  - W default and the END_WORD constant (all-ones).
  - Enum loader_state_t {IDLE, LOAD, DONE, ERR}.
- Sub-module inst_ram:
  - 2**A x W array with one synchronous write port (CLK, we, waddr, wdata) and one asynchronous read port (raddr, rdata).
  - No reset.
- inst_loader holds the FSM, the address and count registers, and the read-side masking.

## Test plan
- Reset, then Start, then stream 0x1FF? No: stream 0x03F, 0x100, 0x1FF with InValid held high. Required: Done=1 one cycle after the 0x1FF beat, LoadCount=3, InstOut at addresses 0/1/2 = 0x03F/0x100/0x1FF, address 3 reads 0x1FF.
- Backpressure and bubbles: InValid toggled every other cycle. Required: exactly one write per beat, LoadCount equals the number of beats, no duplicated words.
- Overflow with A=2: stream four non-END words. Required: Overflow=1, Done=0, LoadCount=4, InstOut=0x1FF everywhere. Repeat with the 4th word = 0x1FF. Required: Done=1, Overflow=0.
- Restart: Start asserted mid-load in the same cycle as InValid. Required: that beat is dropped (InReady=0), LoadCount=0 the next cycle, and the new program loads from address 0.
- Reload shorter program: load 5 words, then load 2 words (0x0AA, 0x1FF). Required: addresses 2-4 read 0x1FF, not the stale words.
- Async reset asserted between edges during LOAD. Required: Done, Overflow, InReady and LoadCount are 0 before the next edge, and InstOut=0x1FF.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared definitions for the 9-bit ISA core: word width, halt encoding and
// the instruction loader state type.
package isa_pkg;

  localparam int W_DEF = 9;
  localparam logic [W_DEF-1:0] END_WORD = '1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/inst_ram.sv
// Instruction memory: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module inst_ram #(
  parameter int A = 10,
  parameter int W = 9
) (
  input  logic         CLK,
  input  logic         we,
  input  logic [A-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic [A-1:0] raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem_q [2**A];

  always_ff @(posedge CLK) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_loader.sv
// Streams a program into inst_ram over valid/ready, then serves it to fetch.
// Reads outside the loaded program, or while not DONE, return the halt word.
module inst_loader
  import isa_pkg::*;
#(
  parameter int A = 10,
  parameter int W = W_DEF
) (
  input  logic         CLK,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic [W-1:0] InData,
  input  logic         InValid,
  output logic         InReady,
  input  logic [A-1:0] InstAddress,
  output logic [W-1:0] InstOut,
  output logic         Done,
  output logic         Overflow,
  output logic [A:0]   LoadCount
);

  localparam logic [W-1:0] END_W    = {W{1'b1}};
  localparam logic [A-1:0] ADDR_MAX = {A{1'b1}};

  loader_state_t state_q;
  logic [A-1:0]  addr_q;
  logic [A:0]    count_q;
  logic          done_q;
  logic          ovf_q;
  logic          beat;
  logic [W-1:0]  rdata;

  // Start wins over a simultaneous beat, so ready drops while it is high.
  assign InReady = (state_q == LOAD) && !Start;
  assign beat    = InValid && InReady;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (Start) begin
      state_q <= LOAD;
      addr_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == LOAD && beat) begin
      count_q <= count_q + (A+1)'(1);
      if (InData == END_W) begin
        state_q <= DONE;
        done_q  <= 1'b1;
      end else if (addr_q == ADDR_MAX) begin
        // Memory full without a halt word: stop rather than wrap.
        state_q <= ERR;
        ovf_q   <= 1'b1;
      end else begin
        addr_q <= addr_q + A'(1);
      end
    end
  end

  inst_ram #(.A(A), .W(W)) u_ram (
    .CLK   (CLK),
    .we    (beat),
    .waddr (addr_q),
    .wdata (InData),
    .raddr (InstAddress),
    .rdata (rdata)
  );

  assign InstOut   = (state_q == DONE && {1'b0, InstAddress} < count_q) ? rdata : END_W;
  assign Done      = done_q;
  assign Overflow  = ovf_q;
  assign LoadCount = count_q;

endmodule
